sync_rx_fifo: RTL and testbench

Destination-domain receive buffer that sits directly downstream of the multi-flop bus synchronizer. Captures the synchronized bus on every synchronizer `enable_pulse` into a small circular FIFO. Presents entries to the local consumer through a valid/ready handshake. Flags and counts words lost to overflow, so a burst of source updates can be absorbed without the consumer sampling the synchronizer output directly.

---
 rtl/sync_rx_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 17 +
 rtl/sync_rx_fifo.sv | 57 +++++
 tb/tb_sync_rx_fifo.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sync_rx_fifo_pkg.sv
// sync_rx_fifo_pkg: shared defaults and sizing helper for the receive FIFO
package sync_rx_fifo_pkg;
  localparam int def_bus_width = 4;
  localparam int def_depth = 4;
  localparam int def_cnt_width = 8;
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: unreset register array with synchronous write and asynchronous read
module sync_fifo_mem #(
  parameter int bus_width = 4,
  parameter int depth = 4,
  parameter int aw = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [aw-1:0]        waddr,
  input  logic [bus_width-1:0] wdata,
  input  logic [aw-1:0]        raddr,
  output logic [bus_width-1:0] rdata
);
  logic [bus_width-1:0] mem [depth];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_rx_fifo.sv
// sync_rx_fifo: captures synchronizer words into a FWFT FIFO with sticky overflow and saturating drop count
module sync_rx_fifo
  import sync_rx_fifo_pkg::*;
#(
  parameter int bus_width = def_bus_width,
  parameter int depth = def_depth,
  parameter int cnt_width = def_cnt_width
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [bus_width-1:0]        sync,
  input  logic                        enable_pulse,
  output logic [bus_width-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        full,
  output logic [log2_ceil(depth):0]   level,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic [cnt_width-1:0]        drop_cnt
);
  localparam int aw = log2_ceil(depth);
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [bus_width-1:0] rd_word;
  logic push, pop, drop;
  assign full = level == (aw+1)'(depth);
  assign out_valid = level != '0;
  assign pop = out_valid && out_ready;
  assign push = enable_pulse && (!full || pop);
  assign drop = enable_pulse && full && !pop;
  assign out_data = out_valid ? rd_word : '0;
  sync_fifo_mem #(.bus_width(bus_width), .depth(depth), .aw(aw)) u_mem (
    .clk(CLK),
    .we(push && !RST),
    .waddr(wr_ptr),
    .wdata(sync),
    .raddr(rd_ptr),
    .rdata(rd_word)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + aw'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + aw'(1) : rd_ptr;
      level <= (push && !pop) ? level + (aw+1)'(1) : (pop && !push) ? level - (aw+1)'(1) : level;
      overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
      // a drop in the same cycle as a clear restarts the count at one
      drop_cnt <= drop ? (ovf_clr ? cnt_width'(1) : (&drop_cnt) ? drop_cnt : drop_cnt + cnt_width'(1))
                       : ovf_clr ? '0 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_sync_rx_fifo.sv
// tb_sync_rx_fifo: directed scoreboard bench for the receive FIFO
module tb_sync_rx_fifo;
  logic clk = 0, rst = 1;
  logic [3:0] sync = 0;
  logic enable_pulse = 0, out_ready = 0, ovf_clr = 0;
  logic [3:0] out_data;
  logic out_valid, full, overflow;
  logic [2:0] level;
  logic [7:0] drop_cnt;
  int pass_cnt = 0, total_cnt = 0;
  int exp_q[$];
  int rx[$];
  bit e2e = 0;

  sync_rx_fifo dut (
    .CLK(clk), .RST(rst), .sync(sync), .enable_pulse(enable_pulse),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (e2e) rx.push_back(int'(out_data));
      else if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
      else check("pop_data", int'(out_data), exp_q.pop_front());
    end

  task automatic cyc(input logic en, input logic [3:0] d, input logic rdy, input logic clr);
    enable_pulse = en;
    sync = d;
    out_ready = rdy;
    ovf_clr = clr;
    @(posedge clk);
    #1;
    enable_pulse = 0;
    out_ready = 0;
    ovf_clr = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  initial begin
    int gaps, bad, d;
    enable_pulse = 1;
    sync = 4'h7;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    enable_pulse = 0;
    rst = 0;
    cyc(0, 0, 0, 0);
    // fill and drain
    cyc(1, 4'h1, 0, 0);
    check("fwft_valid", out_valid, 1);
    check("fwft_data", out_data, 1);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h3, 0, 0);
    cyc(1, 4'h4, 0, 0);
    check("fill_full", full, 1);
    check("fill_level", level, 4);
    exp_q = '{1, 2, 3, 4};
    drain(4);
    check("drain_valid", out_valid, 0);
    check("drain_level", level, 0);
    check("drain_data", out_data, 0);
    // overflow with contents preserved
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0);
    repeat (3) cyc(1, 4'hA, 0, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", drop_cnt, 3);
    check("ovf_level", level, 4);
    check("ovf_head", out_data, 1);
    // push+pop while full
    exp_q.push_back(1);
    cyc(1, 4'h5, 1, 0);
    check("pp_level", level, 4);
    check("pp_full", full, 1);
    check("pp_cnt", drop_cnt, 3);
    exp_q = '{2, 3, 4, 5};
    drain(4);
    check("pp_empty", out_valid, 0);
    // clear colliding with a drop
    for (int i = 6; i <= 9; i++) cyc(1, 4'(i), 0, 0);
    cyc(1, 4'hB, 0, 1);
    check("clr_drop_ovf", overflow, 1);
    check("clr_drop_cnt", drop_cnt, 1);
    cyc(0, 0, 0, 1);
    check("clr_ovf", overflow, 0);
    check("clr_cnt", drop_cnt, 0);
    exp_q = '{6, 7, 8, 9};
    drain(4);
    // saturation
    for (int i = 12; i <= 15; i++) cyc(1, 4'(i), 0, 0);
    repeat (260) cyc(1, 4'h0, 0, 0);
    check("sat_cnt", drop_cnt, 255);
    check("sat_ovf", overflow, 1);
    cyc(0, 0, 0, 1);
    check("sat_clr", drop_cnt, 0);
    exp_q = '{12, 13, 14, 15};
    drain(4);
    // mid-operation reset ignores enable_pulse
    cyc(1, 4'h3, 0, 0);
    cyc(1, 4'h4, 0, 0);
    rst = 1;
    cyc(1, 4'h9, 0, 0);
    check("mrst_level", level, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    rst = 0;
    cyc(0, 0, 0, 0);
    check("mrst_stay_empty", level, 0);
    // end-to-end stream from a free-running 4-bit source
    e2e = 1;
    for (int i = 0; i < 20; i++) cyc(1, 4'(i), 1'(i % 2), 0);
    for (int k = 0; k < 10 && out_valid; k++) cyc(0, 0, 1, 0);
    check("e2e_drained", out_valid, 0);
    check("e2e_drops", drop_cnt, 6);
    check("e2e_rx_count", rx.size(), 14);
    check("e2e_first", rx.size() > 0 ? rx[0] : -1, 0);
    gaps = 0;
    bad = 0;
    for (int k = 1; k < rx.size(); k++) begin
      d = (rx[k] - rx[k-1]) & 15;
      if (d == 0) bad++;
      else gaps += d - 1;
    end
    check("e2e_monotonic", bad, 0);
    check("e2e_gaps", gaps, int'(drop_cnt));
    check("e2e_last", rx.size() > 0 ? rx[rx.size()-1] : -1, 3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
